// File: rtl/unfilter_pkg.sv
// rtl/unfilter_pkg.sv - shared widths, filter type and FSM state encodings for unfilter
// Holds the shared width defines (overridable from the command line), filter type
// encodings and the FSM state encoding. No ports.
`ifndef SIZE_W_WD
`define SIZE_W_WD 8
`endif
`ifndef SIZE_H_WD
`define SIZE_H_WD 8
`endif
`ifndef SIZE_W_MAX
`define SIZE_W_MAX 16
`endif
`ifndef DATA_PXL_WD
`define DATA_PXL_WD 8
`endif

package unfilter_pkg;

  localparam int LANES = `DATA_PXL_WD / 8;

  typedef enum logic [2:0] {
    FLT_NONE  = 3'd0,
    FLT_SUB   = 3'd1,
    FLT_UP    = 3'd2,
    FLT_AVG   = 3'd3,
    FLT_PAETH = 3'd4
  } flt_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TYPE = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/unfilter_if.sv
// rtl/unfilter_if.sv - frame control and pixel stream bundle for unfilter
// slave  : cfg_w_i/cfg_h_i/start_i/val_i/dat_i in, done_o/val_o/dat_o/err_o out (DUT side)
// master : the mirror image (source/sink side)
`ifndef SIZE_W_WD
`define SIZE_W_WD 8
`endif
`ifndef SIZE_H_WD
`define SIZE_H_WD 8
`endif
`ifndef DATA_PXL_WD
`define DATA_PXL_WD 8
`endif

interface unfilter_if;
  logic [`SIZE_W_WD-1:0]   cfg_w_i;
  logic [`SIZE_H_WD-1:0]   cfg_h_i;
  logic                    start_i;
  logic                    done_o;
  logic                    val_i;
  logic [`DATA_PXL_WD-1:0] dat_i;
  logic                    val_o;
  logic [`DATA_PXL_WD-1:0] dat_o;
  logic                    err_o;

  modport slave (
    input  cfg_w_i, cfg_h_i, start_i, val_i, dat_i,
    output done_o, val_o, dat_o, err_o
  );

  modport master (
    output cfg_w_i, cfg_h_i, start_i, val_i, dat_i,
    input  done_o, val_o, dat_o, err_o
  );
endinterface

// File: rtl/unfilter_lane.sv
// rtl/unfilter_lane.sv - combinational inverse PNG predictor for one 8-bit lane
// Ports: type_i (filter type), d_i (filtered byte), a_i/b_i/c_i (left, up, up-left
// neighbours, already zeroed at row/column edges), out_o (reconstructed byte).
// UNFILTER_PAETH_EN: when defined the Paeth predictor is built.
module unfilter_lane
  import unfilter_pkg::*;
(
  input  flt_e       type_i,
  input  logic [7:0] d_i,
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  input  logic [7:0] c_i,
  output logic [7:0] out_o
);

  // 9-bit sum so the average does not lose the carry
  logic [8:0] sum_ab;
  assign sum_ab = {1'b0, a_i} + {1'b0, b_i};

`ifdef UNFILTER_PAETH_EN
  logic signed [9:0] da, db, pa, pb, pc, pc_raw;
  logic [7:0]        paeth;

  assign db     = $signed({2'b00, b_i}) - $signed({2'b00, c_i});
  assign da     = $signed({2'b00, a_i}) - $signed({2'b00, c_i});
  assign pc_raw = da + db;  // a + b - 2c
  assign pa     = (db < 0) ? -db : db;
  assign pb     = (da < 0) ? -da : da;
  assign pc     = (pc_raw < 0) ? -pc_raw : pc_raw;

  always_comb begin
    paeth = c_i;
    if (pa <= pb && pa <= pc) paeth = a_i;
    else if (pb <= pc)        paeth = b_i;
  end
`else
  logic unused_c;
  assign unused_c = ^c_i;
`endif

  always_comb begin
    out_o = d_i;
    case (type_i)
      FLT_SUB:   out_o = d_i + a_i;
      FLT_UP:    out_o = d_i + b_i;
      FLT_AVG:   out_o = d_i + sum_ab[8:1];
`ifdef UNFILTER_PAETH_EN
      FLT_PAETH: out_o = d_i + paeth;
`endif
      default:   out_o = d_i;
    endcase
  end

endmodule

// File: rtl/unfilter.sv
// rtl/unfilter.sv - PNG scanline de-filter engine with previous-row line buffer
// Ports: clk, rstn (async active-low), bus (unfilter_if.slave): cfg_w_i/cfg_h_i sampled
// on start_i in IDLE; per row one type beat then cfg_w pixel beats on val_i/dat_i;
// val_o/dat_o one cycle after each pixel; done_o pulse; sticky err_o on illegal type.
// UNFILTER_PAETH_EN: when defined type 4 is Paeth, otherwise it is illegal.
module unfilter
  import unfilter_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  unfilter_if.slave  bus
);

  localparam int DW     = `DATA_PXL_WD;
  localparam int WW     = `SIZE_W_WD;
  localparam int HW     = `SIZE_H_WD;
  localparam int IDX_WD = (`SIZE_W_MAX > 1) ? $clog2(`SIZE_W_MAX) : 1;

  state_e          state_q, state_d;
  logic [WW-1:0]   cfg_w_q, cnt_w_q;
  logic [HW-1:0]   cfg_h_q, cnt_h_q;
  flt_e            type_q;
  logic            err_q, val_q, done_q;
  logic [DW-1:0]   dat_q, c_q;
  logic [DW-1:0]   lbuf_q [`SIZE_W_MAX];

  logic            start_go, type_beat, data_beat, last_col, last_row;
  logic            type_legal;
  flt_e            type_in;
  logic [7:0]      type_raw;
  logic [IDX_WD-1:0] idx;
  logic [DW-1:0]   a_v, b_v, c_v, rec;

  assign start_go  = (state_q == ST_IDLE) && bus.start_i;
  assign type_beat = (state_q == ST_TYPE) && bus.val_i;
  assign data_beat = (state_q == ST_DATA) && bus.val_i;
  assign last_col  = (cnt_w_q == cfg_w_q - WW'(1));
  assign last_row  = (cnt_h_q == cfg_h_q - HW'(1));

  assign type_raw = bus.dat_i[7:0];
`ifdef UNFILTER_PAETH_EN
  assign type_legal = (type_raw <= 8'd4);
`else
  assign type_legal = (type_raw <= 8'd3);
`endif
  // Illegal types are folded to None here so the lanes never see them
  assign type_in = type_legal ? flt_e'(type_raw[2:0]) : FLT_NONE;

  // Neighbours: the buffer is never cleared, so row 0 and column 0 are masked here
  assign idx = cnt_w_q[IDX_WD-1:0];
  assign a_v = (cnt_w_q == '0) ? '0 : dat_q;
  assign b_v = (cnt_h_q == '0) ? '0 : lbuf_q[idx];
  assign c_v = (cnt_w_q == '0 || cnt_h_q == '0) ? '0 : c_q;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    unfilter_lane u_lane (
      .type_i (type_q),
      .d_i    (bus.dat_i[8*l +: 8]),
      .a_i    (a_v[8*l +: 8]),
      .b_i    (b_v[8*l +: 8]),
      .c_i    (c_v[8*l +: 8]),
      .out_o  (rec[8*l +: 8])
    );
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.start_i) state_d = ST_TYPE;
      ST_TYPE: if (bus.val_i)   state_d = ST_DATA;
      ST_DATA: if (data_beat && last_col) state_d = last_row ? ST_DONE : ST_TYPE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      cfg_w_q <= '0;
      cfg_h_q <= '0;
      cnt_w_q <= '0;
      cnt_h_q <= '0;
      type_q  <= FLT_NONE;
      err_q   <= 1'b0;
      val_q   <= 1'b0;
      dat_q   <= '0;
      c_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      val_q   <= data_beat;
      done_q  <= (state_q == ST_DONE);
      if (start_go) begin
        cfg_w_q <= bus.cfg_w_i;
        cfg_h_q <= bus.cfg_h_i;
        cnt_w_q <= '0;
        cnt_h_q <= '0;
        err_q   <= 1'b0;
      end
      if (type_beat) begin
        type_q  <= type_in;
        cnt_w_q <= '0;
        if (!type_legal) err_q <= 1'b1;
      end
      if (data_beat) begin
        dat_q <= rec;
        c_q   <= b_v;
        if (last_col) begin
          if (!last_row) cnt_h_q <= cnt_h_q + HW'(1);
        end else begin
          cnt_w_q <= cnt_w_q + WW'(1);
        end
      end
    end
  end

  // Written after the combinational read, so b always sees the previous row
  always_ff @(posedge clk) begin
    if (data_beat) lbuf_q[idx] <= rec;
  end

  assign bus.val_o  = val_q;
  assign bus.dat_o  = dat_q;
  assign bus.done_o = done_q;
  assign bus.err_o  = err_q;

endmodule
